// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// whole-pipe freeze on data-memory busy, saturating perf counters and a timeout flag.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned LOAD_STALL  = 1,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  branch_taken,
   input  logic                  mem_busy,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_write,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count,
   output logic                  mem_timeout
);

   localparam int unsigned LU_W   = 4;
   localparam int unsigned WAIT_W = 8;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   state_t              ret_state_q, ret_state_d;
   state_t              eff_state;
   logic [LU_W-1:0]     lu_cnt_q, lu_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0]    flush_count_q, flush_count_d;
   logic                mem_timeout_q, mem_timeout_d;
   logic                load_use;

   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
   end

   // Mealy outputs and next state; MEM_WAIT resumes the saved state in the same cycle busy drops
   always_comb begin
      state_d        = state_q;
      ret_state_d    = ret_state_q;
      lu_cnt_d       = lu_cnt_q;
      wait_cnt_d     = wait_cnt_q;
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      mem_timeout_d  = mem_timeout_q;
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_write   = 1'b0;
      eff_state      = (state_q == MEM_WAIT) ? ret_state_q : state_q;

      if (rst) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (mem_busy) begin
         if (state_q != MEM_WAIT) begin
            ret_state_d = state_q;
            state_d     = MEM_WAIT;
         end
         if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
         if (wait_cnt_d >= WAIT_W'(MEM_TIMEOUT)) mem_timeout_d = 1'b1;
      end else begin
         wait_cnt_d = '0;
         if (branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
            state_d      = RUN;
            lu_cnt_d     = '0;
            if (flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
         end else if (eff_state == LU_STALL) begin
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
            state_d      = (lu_cnt_q <= LU_W'(1)) ? RUN : LU_STALL;
            lu_cnt_d     = lu_cnt_q - LU_W'(1);
         end else if (load_use) begin
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
            if (LOAD_STALL > 1) begin
               state_d  = LU_STALL;
               lu_cnt_d = LU_W'(LOAD_STALL - 1);
            end else begin
               state_d = RUN;
            end
         end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            ex_mem_write = 1'b1;
            state_d      = RUN;
         end
      end

      if (!rst && !pc_write && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= RUN;
         ret_state_q    <= RUN;
         lu_cnt_q       <= '0;
         wait_cnt_q     <= '0;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
         mem_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         ret_state_q    <= ret_state_d;
         lu_cnt_q       <= lu_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
         mem_timeout_q  <= mem_timeout_d;
      end
   end

   assign state        = state_q;
   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
   assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two parameterisations driven in lockstep and
// checked against a bubbles-remaining reference model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, branch_taken = 0, mem_busy = 0;

   logic        a_pc, a_ifw, a_iff, a_idf, a_exw, a_tmo;
   logic [1:0]  a_state;
   logic [3:0]  a_stall, a_flush;
   logic        b_pc, b_ifw, b_iff, b_idf, b_exw, b_tmo;
   logic [1:0]  b_state;
   logic [15:0] b_stall, b_flush;
   logic [7:0]  a_vec, b_vec;

   int checks = 0;
   int errors = 0;

   // model state, index 0 = instance a, 1 = instance b
   int ls   [2] = '{3, 1};
   int tout [2] = '{8, 255};
   int cmax [2] = '{15, 65535};
   int bub [2], busy_run [2], stall_n [2], flush_n [2];
   bit in_wait [2], tmo [2];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .MEM_TIMEOUT(8), .CNT_W(4)) u_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(a_pc), .if_id_write(a_ifw),
      .if_id_flush(a_iff), .id_ex_flush(a_idf), .ex_mem_write(a_exw), .state(a_state),
      .stall_cycles(a_stall), .flush_count(a_flush), .mem_timeout(a_tmo));

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1), .MEM_TIMEOUT(255), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(b_pc), .if_id_write(b_ifw),
      .if_id_flush(b_iff), .id_ex_flush(b_idf), .ex_mem_write(b_exw), .state(b_state),
      .stall_cycles(b_stall), .flush_count(b_flush), .mem_timeout(b_tmo));

   assign a_vec = {a_pc, a_ifw, a_iff, a_idf, a_exw, a_state, a_tmo};
   assign b_vec = {b_pc, b_ifw, b_iff, b_idf, b_exw, b_state, b_tmo};

   function automatic bit hazard();
      return ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
   endfunction

   // expected {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, state, mem_timeout}
   function automatic logic [7:0] exp_vec(input int i);
      logic [4:0] c;
      logic [1:0] st;
      st = in_wait[i] ? 2'd2 : (bub[i] > 0 ? 2'd1 : 2'd0);
      if (rst)                      begin c = 5'b00110; st = 2'd0; end
      else if (mem_busy)            c = 5'b00000;
      else if (branch_taken)        c = 5'b11111;
      else if (bub[i] > 0 || hazard()) c = 5'b00011;
      else                          c = 5'b11001;
      return {c, st, rst ? 1'b0 : logic'(tmo[i])};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         bub[i] = 0; busy_run[i] = 0; stall_n[i] = 0; flush_n[i] = 0;
         in_wait[i] = 0; tmo[i] = 0;
      end
   endtask

   task automatic model_step(input int i);
      bit lu;
      lu = hazard();
      if (mem_busy) begin
         in_wait[i] = 1;
         if (busy_run[i] < 255) busy_run[i]++;
         if (busy_run[i] >= tout[i]) tmo[i] = 1;
         if (stall_n[i] < cmax[i]) stall_n[i]++;
      end else begin
         in_wait[i] = 0;
         busy_run[i] = 0;
         if (branch_taken) begin
            bub[i] = 0;
            if (flush_n[i] < cmax[i]) flush_n[i]++;
         end else if (bub[i] > 0 || lu) begin
            bub[i] = (bub[i] > 0) ? bub[i] - 1 : ls[i] - 1;
            if (stall_n[i] < cmax[i]) stall_n[i]++;
         end
      end
   endtask

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                        input logic mr, input logic [4:0] rd, input logic br, input logic bz);
      id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      ex_mem_read = mr; ex_rd = rd; branch_taken = br; mem_busy = bz;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) for (int i = 0; i < 2; i++) model_step(i);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1 model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      checks++; if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL reset_a: got %b want %b", a_vec, exp_vec(0)); end
      checks++; if (b_vec !== exp_vec(1)) begin errors++; $display("FAIL reset_b: got %b want %b", b_vec, exp_vec(1)); end
      @(posedge clk); #1 rst = 1'b0;
      // load-use on instance a, then reset while it sits in LU_STALL with two bubbles left
      drive(0, 5, 0, 1, 1, 5, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL pre_reset_state: got %0d want 1", a_state); end
      rst = 1'b1;
      #1 model_reset();
      checks++; if (a_state !== 2'd0 || a_iff !== 1'b1 || a_pc !== 1'b0)
         begin errors++; $display("FAIL mid_reset: state %0d iff %b pc %b want 0 1 0", a_state, a_iff, a_pc); end
      @(posedge clk); #1 rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (a_pc !== 1'b1 || a_stall !== 4'd0)
         begin errors++; $display("FAIL post_reset: pc %b stall %0d want 1 0", a_pc, a_stall); end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(0, 5, 0, 1, 1, 5, 0, 0);
      checks++; if (b_pc !== 1'b0 || b_idf !== 1'b1)
         begin errors++; $display("FAIL lu_b_bubble: pc %b idf %b want 0 1", b_pc, b_idf); end
      checks++; if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL lu_a_vec: got %b want %b", a_vec, exp_vec(0)); end
      tick();
      drive(0, 5, 0, 1, 0, 5, 0, 0);
      checks++; if (b_pc !== 1'b1 || b_stall !== 16'd1)
         begin errors++; $display("FAIL lu_b_after: pc %b stall %0d want 1 1", b_pc, b_stall); end
      tick();
      drive(0, 0, 0, 1, 1, 0, 0, 0);
      checks++; if (b_pc !== 1'b1) begin errors++; $display("FAIL lu_rd0: pc %b want 1", b_pc); end
      tick();
      drive(0, 5, 0, 0, 1, 5, 0, 0);
      checks++; if (b_pc !== 1'b1) begin errors++; $display("FAIL lu_noread: pc %b want 1", b_pc); end
      checks++; if (b_vec !== exp_vec(1)) begin errors++; $display("FAIL lu_b_vec: got %b want %b", b_vec, exp_vec(1)); end
      tick();
   endtask

   task automatic test_lu_branch();
      logic [1:0] st_seq [4];
      logic       pc_seq [4];
      st_seq = '{2'd0, 2'd1, 2'd1, 2'd0};
      pc_seq = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         if (k == 0) drive(7, 0, 1, 0, 1, 7, 0, 0);
         else        drive(0, 0, 0, 0, 0, 0, 0, 0);
         checks++; if (a_state !== st_seq[k] || a_pc !== pc_seq[k])
            begin errors++; $display("FAIL lu3_seq[%0d]: state %0d pc %b want %0d %b", k, a_state, a_pc, st_seq[k], pc_seq[k]); end
         tick();
      end
      drive(7, 0, 1, 0, 1, 7, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (a_state !== 2'd1 || a_vec !== exp_vec(0))
         begin errors++; $display("FAIL lu3_branch: got %b want %b", a_vec, exp_vec(0)); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (a_state !== 2'd0 || a_pc !== 1'b1 || a_flush !== 4'd1)
         begin errors++; $display("FAIL lu3_abort: state %0d pc %b flush %0d want 0 1 1", a_state, a_pc, a_flush); end
      tick();
   endtask

   task automatic test_mem_wait();
      do_reset();
      drive(3, 0, 1, 0, 1, 3, 0, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1);
         checks++; if (a_vec !== exp_vec(0) || {a_pc, a_ifw, a_exw, a_idf} !== 4'b0)
            begin errors++; $display("FAIL busy[%0d]: got %b want %b", k, a_vec, exp_vec(0)); end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         checks++; if (a_vec !== exp_vec(0) || a_pc !== (k == 2))
            begin errors++; $display("FAIL resume[%0d]: got %b want %b", k, a_vec, exp_vec(0)); end
         tick();
      end
      checks++; if (a_stall !== 4'd7) begin errors++; $display("FAIL wait_stalls: got %0d want 7", a_stall); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1);
         checks++; if (a_tmo !== 1'b0) begin errors++; $display("FAIL tmo_early[%0d]: got %b want 0", k, a_tmo); end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         checks++; if (a_tmo !== 1'b1 || b_tmo !== 1'b0)
            begin errors++; $display("FAIL tmo_sticky[%0d]: a %b b %b want 1 0", k, a_tmo, b_tmo); end
         tick();
      end
      do_reset();
      checks++; if (a_tmo !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", a_tmo); end
   endtask

   task automatic test_flush_sat();
      do_reset();
      for (int k = 0; k < 19; k++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (a_flush !== 4'd15 || b_flush !== 16'd19)
         begin errors++; $display("FAIL flush_sat: a %0d b %0d want 15 19", a_flush, b_flush); end
   endtask

   task automatic test_random();
      int busy_left = 0;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 10);
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
               $urandom_range(0, 7) == 0, busy_left > 0);
         if (busy_left > 0) busy_left--;
         checks++; if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL rnd_a[%0d]: got %b want %b", k, a_vec, exp_vec(0)); end
         checks++; if (b_vec !== exp_vec(1)) begin errors++; $display("FAIL rnd_b[%0d]: got %b want %b", k, b_vec, exp_vec(1)); end
         checks++; if (a_stall !== 4'(stall_n[0]) || a_flush !== 4'(flush_n[0]))
            begin errors++; $display("FAIL rnd_a_cnt[%0d]: stall %0d flush %0d want %0d %0d", k, a_stall, a_flush, stall_n[0], flush_n[0]); end
         checks++; if (b_stall !== 16'(stall_n[1]) || b_flush !== 16'(flush_n[1]))
            begin errors++; $display("FAIL rnd_b_cnt[%0d]: stall %0d flush %0d want %0d %0d", k, b_stall, b_flush, stall_n[1], flush_n[1]); end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_use();
      test_lu_branch();
      test_mem_wait();
      test_timeout();
      test_flush_sat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enables and flushes for the PC, IF_ID, ID_EX and EX_MEM registers.
- Detects load-use hazards against the instruction in EX, applies branch-taken flushes, and freezes the whole pipe while data memory is busy.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- REG_ADDR_W, 5: register-specifier width.
- LOAD_STALL, 1: total bubble cycles inserted per load-use hazard (1..15).
- MEM_TIMEOUT, 255: consecutive mem_busy cycles that set mem_timeout (1..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_busy  in  1  data memory not ready; pipe must hold
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF_ID load enable
- if_id_flush  out  1  IF_ID loads NOP/zero
- id_ex_flush  out  1  ID_EX loads bubble
- ex_mem_write  out  1  EX_MEM load enable
- state  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
- flush_count  out  CNT_W  saturating count of branch flushes
- mem_timeout  out  1  sticky timeout flag

Behaviour:
- While rst=1 (async):
  - state=RUN, internal counters 0, perf counters 0, mem_timeout=0.
  - Outputs forced: pc_write=0, if_id_write=0, ex_mem_write=0, if_id_flush=1, id_ex_flush=1.
- Outputs are combinational from the registered state and the current inputs (Mealy); the hazard response appears in the same cycle.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- eff_state = saved ret_state when state==MEM_WAIT, otherwise state.
- Priority order: mem_busy > branch_taken > load_use / LU_STALL.
- mem_busy=1 (any state):
  - All enables 0, both flushes 0.
  - If state!=MEM_WAIT, save ret_state=state and go to MEM_WAIT.
  - The LU_STALL bubble counter does not advance.
  - wait_cnt increments; when it reaches MEM_TIMEOUT, set mem_timeout (sticky until reset).
- MEM_WAIT with mem_busy=0: behave exactly as eff_state for outputs and next state in that same cycle, with no extra cycle. wait_cnt clears.
- branch_taken=1, mem_busy=0:
  - pc_write=1, if_id_write=1, ex_mem_write=1, if_id_flush=1, id_ex_flush=1.
  - Next state RUN; any pending LU_STALL is aborted.
  - flush_count +1.
- RUN, no branch, load_use=1:
  - pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1.
  - If LOAD_STALL>1: go to LU_STALL with lu_cnt=LOAD_STALL-1. Otherwise stay in RUN.
- LU_STALL (no busy, no branch):
  - Same outputs as the load_use cycle.
  - lu_cnt decrements; at 1 → RUN next cycle.
- RUN, nothing pending: pc_write=1, if_id_write=1, ex_mem_write=1, both flushes 0.
- stall_cycles increments on every non-reset cycle with pc_write=0.
- Both perf counters saturate at all-ones.
- ex_rd==0 never causes a stall.
- Simultaneous mem_busy and branch_taken: the pipe freezes, and the branch is applied in the first cycle mem_busy=0 (EX is held, so branch_taken remains asserted).

Test Plan:
- Reset pulse mid-LU_STALL (LOAD_STALL=3, lu_cnt=2): state→0 immediately, if_id_flush=1 while rst=1; after release, pc_write=1 with clean inputs.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, LOAD_STALL=1: exactly one cycle of pc_write=0, id_ex_flush=1, stall_cycles=1. Same stimulus with ex_rd=0 or id_uses_rs2=0: no stall.
- LOAD_STALL=3 load-use: 3 consecutive bubble cycles, state sequence 0,1,1,0; branch_taken in the 2nd cycle aborts → RUN, flush_count=1.
- mem_busy held 4 cycles during LU_STALL: all enables 0; state=2; lu_cnt frozen; on busy drop, the remaining bubbles resume in the same cycle.
- mem_busy held MEM_TIMEOUT=8 cycles: mem_timeout=1 on the 8th, stays 1 after busy drops until rst.
- Drive 2^CNT_W+3 branches (CNT_W=4, 19 branches): flush_count saturates at 15.
